// File: rtl/led_pattern_sequencer.sv
// Green-LED pattern sequencer: debounced push-button commands drive mode, speed
// and pause, and a rate-scaled accumulator paces blink/chase/bounce patterns.
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic [3:0] KEY,
  output logic [7:0] LEDG,
  output logic [9:0] LEDR
);

  localparam int unsigned NKEY  = 4;
  localparam int unsigned ACC_W = 26;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_BOUNCE = 2'b10
  } mode_t;

  logic [NKEY-1:0]  key_s1, key_s2;
  logic [NKEY-1:0]  deb, deb_d, press;
  logic [DEB_W-1:0] deb_cnt [NKEY];

  mode_t            mode;
  logic [3:0]       speed;
  logic             paused;
  logic             dir_right;
  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] acc_sum;
  logic             tick_due;

  // Synchronizer is left unreset so a key held through reset is seen right away.
  always_ff @(posedge CLOCK_50) begin
    key_s1 <= KEY;
    key_s2 <= key_s1;
  end

  // Per-key debouncer; press is a one-cycle pulse on the accepted falling level.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      deb   <= '1;
      deb_d <= '1;
      press <= '0;
      for (int unsigned k = 0; k < NKEY; k++) deb_cnt[k] <= '0;
    end else begin
      deb_d <= deb;
      press <= deb_d & ~deb;
      for (int unsigned k = 0; k < NKEY; k++) begin
        if (key_s2[k]) begin
          deb[k]     <= 1'b1;
          deb_cnt[k] <= '0;
        end else if (deb[k]) begin
          if (deb_cnt[k] == DEB_W'(DEB_CYCLES - 1)) begin
            deb[k]     <= 1'b0;
            deb_cnt[k] <= '0;
          end else begin
            deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
          end
        end
      end
    end
  end

  // One-hot speed doubles as the accumulator step (1/2/4/8).
  assign acc_sum  = {1'b0, acc} + SUM_W'(speed);
  assign tick_due = (acc_sum >= SUM_W'(TICK_DIV));

  // Command priority KEY3 > KEY0 > KEY1 > KEY2; any command suppresses that cycle's tick.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      mode      <= MODE_BLINK;
      speed     <= 4'b0001;
      paused    <= 1'b0;
      dir_right <= 1'b0;
      acc       <= '0;
      LEDG      <= 8'h00;
    end else if (press[3]) begin
      paused <= ~paused;
    end else if (press[0]) begin
      acc       <= '0;
      dir_right <= 1'b0;
      case (mode)
        MODE_BLINK: begin
          mode <= MODE_CHASE;
          LEDG <= 8'h01;
        end
        MODE_CHASE: begin
          mode <= MODE_BOUNCE;
          LEDG <= 8'h01;
        end
        default: begin
          mode <= MODE_BLINK;
          LEDG <= 8'h00;
        end
      endcase
    end else if (press[1]) begin
      acc <= '0;
      if (!speed[3]) speed <= speed << 1;
    end else if (press[2]) begin
      acc <= '0;
      if (!speed[0]) speed <= speed >> 1;
    end else if (!paused) begin
      if (tick_due) begin
        acc <= '0;
        case (mode)
          MODE_BLINK: LEDG <= ~LEDG;
          MODE_CHASE: LEDG <= {LEDG[6:0], LEDG[7]};
          default: begin
            if (!dir_right) begin
              if (LEDG == 8'h80) begin
                LEDG      <= 8'h40;
                dir_right <= 1'b1;
              end else begin
                LEDG <= LEDG << 1;
              end
            end else begin
              if (LEDG == 8'h01) begin
                LEDG      <= 8'h02;
                dir_right <= 1'b0;
              end else begin
                LEDG <= LEDG >> 1;
              end
            end
          end
        endcase
      end else begin
        acc <= acc + ACC_W'(speed);
      end
    end
  end

  assign LEDR = {paused, 3'b000, mode, speed};

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Button-driven controller for the green-LED blink datapath on the 50 MHz board. Debounces the four push buttons and turns them into one-cycle commands. Owns a mode/speed/pause state machine and a rate-scaled tick accumulator. Drives LEDG with blink, chase or bounce patterns and shows its state on LEDR.

## Interface
- TICK_DIV, 50_000_000: base pattern period in clock cycles at 1x speed (26-bit range).
- DEB_CYCLES, 1_000_000: consecutive stable-low samples needed to accept a press (20 ms).
- CLOCK_50 in 1: system clock.
- RST in 1: reset, synchronous, active-high, highest priority.
- KEY in 4: push buttons, active-low, asynchronous to CLOCK_50.
- LEDG out 8: pattern output.
- LEDR out 10: status; [3:0] one-hot speed (bit0=1x … bit3=8x), [5:4] mode (00 BLINK, 01 CHASE, 10 BOUNCE), [9] paused, others 0.

## Operation
- **KEY input path.**
  - Each KEY bit passes through a 2-flop synchronizer, then a per-key debouncer.
  - The debounced level goes low after DEB_CYCLES consecutive low synchronized samples.
  - It returns high on the first high sample.
  - A press event is a one-cycle pulse on the debounced high→low transition. Release produces no event.
- **Commands.**
  - KEY0: mode BLINK→CHASE→BOUNCE→BLINK.
  - KEY1: speed doubles, saturates at 8x.
  - KEY2: speed halves, saturates at 1x.
  - KEY3: toggles RUN/PAUSE.
- **Simultaneous events.** Priority is KEY3 > KEY0 > KEY1 > KEY2. Only the highest event is applied; the others are discarded, not queued.
- **Tick accumulator.**
  - acc is 26 bits; step = 1/2/4/8.
  - In RUN, each cycle: if acc+step ≥ TICK_DIV, then acc←0 and a tick fires; otherwise acc←acc+step.
  - Period = ceil(TICK_DIV/step) cycles.
- **Pause.** acc, LEDG and direction hold. Resume continues from the held acc.
- **Speed or mode change.** acc←0 and no tick fires that cycle. A saturated speed press also clears acc.
- **Mode entry.** On the same edge as the change:
  - BLINK: LEDG←0x00.
  - CHASE and BOUNCE: LEDG←0x01, direction left.
  - Pause does not affect entry loading.
- **Patterns on tick.**
  - BLINK: LEDG←~LEDG.
  - CHASE: rotate left; 0x80→0x01.
  - BOUNCE: shift in the current direction. Direction flips when LEDG is 0x80 (next 0x40) or 0x01 while moving right (next 0x02).
- **Reset values.**
  - State: mode BLINK, step 1, RUN, acc 0, direction left.
  - Outputs: LEDG 0x00, LEDR 0x001.
  - Debounced levels reset to released. A key held through reset therefore produces one event DEB_CYCLES+2 cycles after RST drops.

## Timing
- **Press latency.** KEY low first sampled at edge 0 → LEDR/LEDG reflect the command after edge DEB_CYCLES+3, exactly.
- **Tick output.** LEDG updates on the same edge that clears acc. A tick and a command in the same cycle: the command wins and the tick is dropped.
- **Glitches.** A low pulse shorter than DEB_CYCLES synchronized samples produces no event. Bounce after acceptance produces no second event unless the level goes high and then stays low DEB_CYCLES samples again.
- **Reset mid-operation.** RST high at any edge gives all reset values after that edge, regardless of pending events or acc value.
- **Pause timing.** Entering pause at acc=a, then resuming: the next tick occurs after exactly ceil((TICK_DIV−a)/step) running cycles.

## Test plan
All scenarios use TICK_DIV=16, DEB_CYCLES=4.
- **Reset and 1x blink.** RST 2 cycles, then idle → LEDG=0x00, LEDR=0x001. LEDG=0xFF after 16 cycles, 0x00 after 32.
- **Speed saturation.** KEY1 pressed 4 times (each 8 cycles low, 8 high) → LEDR[3:0] = 0010, 0100, 1000, 1000; tick period 2 cycles. Then KEY2 ×4 → 0100, 0010, 0001, 0001.
- **Chase and bounce.**
  - KEY0 once → LEDR[5:4]=01, LEDG=0x01, 0x02 … 0x80, 0x01 on successive 16-cycle ticks.
  - KEY0 again → LEDR[5:4]=10, LEDG=0x01, 0x02 … 0x80, 0x40 … 0x01, 0x02.
- **Pause and resume.** In CHASE at LEDG=0x04 with acc=10, press KEY3 → LEDR[9]=1; LEDG holds 0x04 for 200 cycles. KEY3 again → LEDR[9]=0; LEDG=0x08 exactly 6 running cycles later.
- **Debounce and priority.**
  - KEY1 low for 3 cycles → no change.
  - KEY3 and KEY1 pressed on the same cycle → only pause toggles; speed unchanged.
  - Latency check: LEDR changes at edge 7 after first low sample.
- **Reset mid-operation.** RST asserted mid-BOUNCE at 8x while KEY0 is held → next edge LEDG=0x00, LEDR=0x001. One KEY0 event follows 6 cycles after RST drops → CHASE.
